// File: rtl/clk_en_pkg.sv
// clk_en_pkg: shared state type and default divide constants for clk_en_prescaler
package clk_en_pkg;
    localparam int DIV_W_DEF   = 8;
    localparam int DIV_RST_DEF = 9;
    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;
endpackage

// File: rtl/prescale_cnt.sv
// prescale_cnt: clearable up-counter flagging when it reaches the terminal count
module prescale_cnt
    import clk_en_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [DIV_W-1:0] tc_val,
    output logic             tc
);
    logic [DIV_W-1:0] r_cnt;
    // clear wins over increment so a terminal cycle restarts the period at 0
    always_ff @(posedge clk) begin
        if (rst || clr) r_cnt <= '0;
        else if (inc) r_cnt <= r_cnt + 1'b1;
    end
    assign tc = r_cnt == tc_val;
endmodule

// File: rtl/clk_en_prescaler.sv
// clk_en_prescaler: run/step clock-enable pulse generator with glitch-free divide reload
module clk_en_prescaler
    import clk_en_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             clkEn,
    output logic             busy,
    output logic             load_pending,
    output logic [DIV_W-1:0] div_active
);
    state_t           r_state, w_state_nxt;
    logic             w_tc, w_term, w_drop, w_direct;
    logic             r_clken, r_pending;
    logic [DIV_W-1:0] r_shadow, r_div_active;
    assign w_term   = (r_state != IDLE) && w_tc;
    assign w_drop   = (r_state == RUN) && !run;
    assign w_direct = div_load && (w_term || (r_state == IDLE && run));
    prescale_cnt #(.DIV_W(DIV_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    ((r_state == IDLE) || w_term || w_drop),
        .inc    (r_state != IDLE),
        .tc_val (r_div_active),
        .tc     (w_tc)
    );
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    // next state: run beats step from IDLE, STEP always finishes its one pulse
    always_comb begin
        w_state_nxt = IDLE;
        unique case (r_state)
            IDLE:    w_state_nxt = run ? RUN : (step ? STEP : IDLE);
            RUN:     w_state_nxt = run ? RUN : IDLE;
            STEP:    w_state_nxt = w_term ? IDLE : STEP;
            default: w_state_nxt = IDLE;
        endcase
    end
    // one-cycle enable after a terminal cycle, suppressed when run is being dropped
    always_ff @(posedge clk) begin
        if (rst) r_clken <= 1'b0;
        else r_clken <= w_term && !w_drop;
    end
    // divide reload only at period boundaries or while idle so no period is truncated
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow     <= DIV_W'(DIV_RST);
            r_div_active <= DIV_W'(DIV_RST);
            r_pending    <= 1'b0;
        end else if (w_direct) begin
            r_shadow     <= div_val;
            r_div_active <= div_val;
            r_pending    <= 1'b0;
        end else if (div_load) begin
            r_shadow     <= div_val;
            r_pending    <= 1'b1;
        end else if (r_pending && (r_state == IDLE || w_term)) begin
            r_div_active <= r_shadow;
            r_pending    <= 1'b0;
        end
    end
    assign clkEn        = r_clken;
    assign busy         = r_state != IDLE;
    assign load_pending = r_pending;
    assign div_active   = r_div_active;
endmodule

// File: tb/tb_clk_en_prescaler.sv
// tb_clk_en_prescaler: directed scenarios plus random run/step/load traffic against a cycle model
module tb_clk_en_prescaler;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         clkEn, busy, load_pending;
    logic [W-1:0] div_active;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    clk_en_prescaler #(.DIV_W(W), .DIV_RST(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .step         (step),
        .div_load     (div_load),
        .div_val      (div_val),
        .clkEn        (clkEn),
        .busy         (busy),
        .load_pending (load_pending),
        .div_active   (div_active)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 idle, 1 free-running, 2 single step; pos = cycles elapsed in current period
    int m_mode, m_pos, m_act, m_shadow, m_nmode;
    bit m_pend, m_en, m_valid, m_term, m_drop;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pos = 0; m_act = 9; m_shadow = 9; m_pend = 0; m_en = 0; m_valid = 1;
        end else if (m_valid) begin
            m_term = (m_mode != 0) && (m_pos == m_act);
            m_drop = (m_mode == 1) && !run;
            m_en = m_term && !m_drop;
            if (div_load && (m_term || (m_mode == 0 && run))) begin
                m_act = int'(div_val); m_shadow = int'(div_val); m_pend = 0;
            end else if (div_load) begin
                m_shadow = int'(div_val); m_pend = 1;
            end else if (m_pend && (m_mode == 0 || m_term)) begin
                m_act = m_shadow; m_pend = 0;
            end
            if (m_mode == 0) m_nmode = run ? 1 : (step ? 2 : 0);
            else if (m_mode == 1) m_nmode = run ? 1 : 0;
            else m_nmode = m_term ? 0 : 2;
            m_pos = (m_mode != 0 && m_nmode != 0 && !m_term) ? m_pos + 1 : 0;
            m_mode = m_nmode;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model clkEn", 32'(clkEn), 32'(m_en));
            chk("model busy", 32'(busy), 32'(m_mode != 0));
            chk("model load_pending", 32'(load_pending), 32'(m_pend));
            chk("model div_active", 32'(div_active), 32'(m_act));
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        chk("reset busy", 32'(busy), 0);
        chk("reset clkEn", 32'(clkEn), 0);
        chk("reset load_pending", 32'(load_pending), 0);
        chk("reset div_active", 32'(div_active), 9);
        rst = 1'b0; div_load = 1'b1; div_val = 8'd3;
        tick();
        chk("idle capture pending", 32'(load_pending), 1);
        chk("idle capture div_active", 32'(div_active), 9);
        div_load = 1'b0;
        tick();
        chk("idle transfer pending", 32'(load_pending), 0);
        chk("idle transfer div_active", 32'(div_active), 3);
        run = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk("div3 pulse train", 32'(clkEn), 32'(c == 5 || c == 9 || c == 13));
        end
        div_load = 1'b1; div_val = 8'd1;
        tick();
        chk("midperiod pending", 32'(load_pending), 1);
        chk("midperiod div_active held", 32'(div_active), 3);
        div_load = 1'b0;
        tick();
        chk("midperiod still pending", 32'(load_pending), 1);
        chk("midperiod no pulse", 32'(clkEn), 0);
        tick();
        chk("reload pulse", 32'(clkEn), 1);
        chk("reload pending clear", 32'(load_pending), 0);
        chk("reload div_active", 32'(div_active), 1);
        for (int c = 18; c <= 21; c++) begin
            tick();
            chk("div1 pulse train", 32'(clkEn), 32'(c % 2));
        end
        div_load = 1'b1; div_val = 8'd0;
        tick();
        div_load = 1'b0;
        for (int c = 23; c <= 27; c++) begin
            tick();
            chk("div0 continuous", 32'(clkEn), 1);
        end
        run = 1'b0;
        tick();
        chk("div0 drop clkEn", 32'(clkEn), 0);
        chk("div0 drop busy", 32'(busy), 0);
        div_load = 1'b1; div_val = 8'd2;
        tick();
        div_load = 1'b0;
        tick();
        chk("step setup div_active", 32'(div_active), 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("step first cycle", 32'(clkEn), 0);
        for (int c = 32; c <= 37; c++) begin
            tick();
            chk("step single pulse", 32'(clkEn), 32'(c == 34));
            if (c == 32) chk("step busy", 32'(busy), 1);
        end
        chk("step done idle", 32'(busy), 0);
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        chk("run+step first cycle", 32'(clkEn), 0);
        for (int c = 39; c <= 47; c++) begin
            tick();
            chk("run beats step", 32'(clkEn), 32'(c == 41 || c == 44 || c == 47));
        end
        run = 1'b0;
        tick();
        chk("run drop idle", 32'(busy), 0);
        run = 1'b1;
        tick();
        tick();
        chk("prereset busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk("midperiod reset clkEn", 32'(clkEn), 0);
        chk("midperiod reset busy", 32'(busy), 0);
        chk("midperiod reset div_active", 32'(div_active), 9);
        rst = 1'b0; run = 1'b0;
        tick();
        chk("post reset no pulse", 32'(clkEn), 0);
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 19) == 0) run = ~run;
            step = ($urandom_range(0, 9) == 0);
            div_load = ($urandom_range(0, 11) == 0);
            div_val = W'($urandom_range(0, 6));
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; run = 1'b0; step = 1'b0; div_load = 1'b0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
